rr_decode_arbiter: RTL
======================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 one-hot select resource among 8 requesters.
- Picks one winner and produces a registered 3-bit index, an enable, and the matching one-hot grant vector, so downstream logic sees exactly one active line at a time.
- Sits between requesting agents and the shared decoder / select path.
- Fairness comes from a rotating priority pointer.

Parameters:
MAX_HOLD, 16, max consecutive grant cycles per owner when HOLD_LIMIT_EN is defined; legal 2..256
CNT_W, 8, hold counter width; must satisfy 2^CNT_W >= MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  8  request vector, bit i = requester i
gnt_idx  output  3  index of current owner, registered
gnt_en  output  1  1 while a grant is active, registered
gnt  output  8  one-hot grant; equals 1<<gnt_idx when gnt_en=1, else 0, registered
busy  output  1  1 when FSM is in GRANT, registered

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous, active-high, sampled on the rising edge.
- Reset values: state=IDLE, ptr=0, gnt_idx=0, gnt_en=0, gnt=8'h00, busy=0, hold_cnt=0.
- Reset asserted mid-grant clears all of these on that edge. No grant is issued while rst=1.

- Internal state:
  - FSM states IDLE, GRANT.
  - ptr[2:0] = highest-priority index.
  - hold_cnt[CNT_W-1:0].

- Winner search: first set bit of the candidate set, scanning ptr, ptr+1, ..., ptr+7, modulo 8 (wrap 7->0).

- IDLE:
  - If req != 0 at an edge: winner w is selected; gnt_idx=w, gnt_en=1, gnt=1<<w, busy=1, hold_cnt=0; go to GRANT.
  - If req == 0: stay IDLE; all outputs 0 except gnt_idx, which holds its last value.
  - Latency: req sampled at edge k gives gnt visible after edge k (1 cycle).

- GRANT, owner o=gnt_idx:
  - Hold: req[o]=1 (and no forced rotation) -> outputs unchanged; hold_cnt increments, saturating at all-ones.
  - Release: req[o]=0 and other requests pending ->
    - ptr=o+1 mod 8;
    - new winner searched from o+1 over req with bit o masked;
    - handover with no bubble: new gnt on the same edge, stay GRANT, hold_cnt=0.
  - Release with no other request -> gnt_en=0, gnt=0, busy=0, ptr=o+1, go to IDLE.
- Requests appearing while another is owned wait; they are never granted concurrently.
- Invariant: gnt is always 0 or exactly one-hot, and gnt[i]=1 implies gnt_idx==i.
- Simultaneous release by owner and assertion by others at the same edge follows the release rules above.
- ptr updates only on an ownership change.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - In GRANT, if hold_cnt == MAX_HOLD-1 and (req & ~(1<<o)) != 0, ownership is forcibly rotated using the release rules, even though req[o]=1.
  - The preempted requester re-competes at lowest priority.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates.
  - Longest single tenure under contention is therefore MAX_HOLD cycles.
- Undefined:
  - No preemption; the owner holds as long as req[o]=1.
  - hold_cnt logic may be removed.
- Ports are identical in both builds.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_en=0, busy=0 throughout.
- From reset, req=8'b0010_0100 -> next edge gnt_idx=2, gnt=8'h04. Drop req[2] -> next edge gnt_idx=5, gnt=8'h20, no bubble cycle.
- Wrap-around:
  - Owner 6 releases while req=8'b0000_0011 -> next grant idx 0.
  - After 0 releases with req[1] still set -> idx 1.
  - After 1 releases with no requests -> IDLE, gnt=0.
- Fairness: all 8 req held, each owner drops req for one cycle after 2 granted cycles and then reasserts it -> grant order 0,1,2,...,7,0; gnt one-hot every cycle.
- Reset mid-operation: rst=1 for one edge during GRANT idx 3 -> gnt=0, busy=0 next cycle. rst=0 with req=8'hFF -> grant idx 0 (ptr reset).
- HOLD_LIMIT_EN, MAX_HOLD=4: req[1] and req[4] held permanently -> grants alternate 1 for 4 cycles, then 4 for 4 cycles. Same build with only req[1] held -> idx 1 kept indefinitely.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 one-hot select path.
// Define HOLD_LIMIT_EN to preempt owners after MAX_HOLD cycles under contention.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 256) ||
      (MAX_HOLD > (1 << CNT_W))) begin : g_bad_cfg
    $error("rr_decode_arbiter: illegal MAX_HOLD/CNT_W");
  end

  // Scan s, s+1, ..., s+7 (mod 8); the lowest offset wins.
  function automatic logic [2:0] pick(
    input logic [7:0] c,
    input logic [2:0] s
  );
    logic [2:0] idx;
    pick = s;
    for (int k = 7; k >= 0; k--) begin
      idx = s + 3'(k);
      if (c[idx]) pick = idx;
    end
  endfunction

  logic [7:0] others;
  logic [2:0] nxt;
  logic       rel;
  logic [2:0] win_idle;
  logic [2:0] win_rel;

`ifdef HOLD_LIMIT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             preempt;

  assign preempt = (hold_cnt == CNT_W'(MAX_HOLD - 1)) && (|others);
`endif

  // gnt is the one-hot of the owner while in GRANT.
  assign others = req & ~gnt;
  assign nxt    = gnt_idx + 3'd1;
  assign win_idle = pick(req, ptr);
  assign win_rel  = pick(others, nxt);

`ifdef HOLD_LIMIT_EN
  assign rel = !req[gnt_idx] || preempt;
`else
  assign rel = !req[gnt_idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_idx <= 3'd0;
      gnt_en  <= 1'b0;
      gnt     <= 8'h00;
      busy    <= 1'b0;
`ifdef HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state   <= GRANT;
            gnt_idx <= win_idle;
            gnt_en  <= 1'b1;
            gnt     <= 8'b1 << win_idle;
            busy    <= 1'b1;
`ifdef HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
          end else begin
            gnt_en <= 1'b0;
            gnt    <= 8'h00;
            busy   <= 1'b0;
          end
        end
        GRANT: begin
          unique case (1'b1)
            !rel: begin
`ifdef HOLD_LIMIT_EN
              if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
`endif
            end
            rel && (|others): begin
              ptr     <= nxt;
              gnt_idx <= win_rel;
              gnt     <= 8'b1 << win_rel;
`ifdef HOLD_LIMIT_EN
              hold_cnt <= '0;
`endif
            end
            default: begin
              state  <= IDLE;
              ptr    <= nxt;
              gnt_en <= 1'b0;
              gnt    <= 8'h00;
              busy   <= 1'b0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
